// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl: word-organised main memory with programmable access latency,
// slaved to the coherency controller's ramREN/ramWEN handshake.
module ram_latency_ctrl #(
    parameter int AW          = 10,
    parameter int LAT         = 3,
    parameter bit LIMIT_CHECK = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   load_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [2**AW];

    logic          err, req, same, start, access;
    logic [AW-1:0] idx_in;

    always_comb begin
        err      = (ramREN && ramWEN) || (LIMIT_CHECK && ((ramaddr >> (AW + 2)) != 32'd0));
        req      = ramREN || ramWEN;
        idx_in   = ramaddr[AW+1:2];
        same     = (op_q == ramWEN) && (idx_in == addr_q) && (!ramWEN || ramstore == data_q);
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ramstate = FREE;
        start    = 1'b0;
        access   = 1'b0;
        if (err) begin
            ramstate = ERROR;
            state_d  = IDLE;
        end else if (!req) begin
            state_d = IDLE;
        end else if (state_q == IDLE || !same) begin
            start = 1'b1;
        end else if (state_q == WAIT) begin
            ramstate = BUSY;
            cnt_d    = cnt_q - 4'd1;
            state_d  = (cnt_q == 4'd1) ? DONE : WAIT;
        end else begin
            ramstate = ACCESS;
            access   = 1'b1;
            state_d  = IDLE;
        end
        // a fresh or changed request re-latches and restarts the latency count
        if (start) begin
            ramstate = BUSY;
            op_d     = ramWEN;
            addr_d   = idx_in;
            data_d   = ramstore;
            cnt_d    = 4'(LAT - 1);
            state_d  = (LAT > 1) ? WAIT : DONE;
        end
        ramload = (access && !op_q) ? rdata_q : load_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (access && !op_q)
                load_q <= rdata_q;
        end
    end

    // read word tracks the index that will be latched next, so it is ready in DONE
    always_ff @(posedge CLK) begin
        if (nRST && access && op_q)
            mem[addr_q] <= data_q;
        rdata_q <= mem[addr_d];
    end
endmodule

// File: tb/tb_ram_latency_ctrl.sv
// tb_ram_latency_ctrl: LAT=3 and LAT=1 instances driven in parallel, checked each cycle
// against a request-age model, plus directed literal expectations.
module tb_ram_latency_ctrl;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [31:0] ld3, ld1;
    logic [1:0]  st3, st1;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    ram_latency_ctrl #(.AW(10), .LAT(3), .LIMIT_CHECK(1'b1)) d3 (
        .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(ld3), .ramstate(st3));
    ram_latency_ctrl #(.AW(10), .LAT(1), .LIMIT_CHECK(1'b1)) d1 (
        .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(ld1), .ramstate(st1));

    // model: a request is served once it has been held unchanged for LAT cycles
    logic [31:0] mm [2][1024];
    bit          mv [2][1024];
    bit          kv [2];
    logic [62:0] kk [2];
    int          age [2];
    logic [31:0] eld [2];
    bit          lk [2] = '{1'b1, 1'b1};
    logic [62:0] key;
    logic [1:0]  es, ist;
    logic [31:0] ild;
    logic [9:0]  ix;
    bit          merr, mreq;

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!nRST) begin
                kv[i]  = 1'b0;
                eld[i] = 32'd0;
                lk[i]  = 1'b1;
            end else begin
                ist  = (i == 0) ? st3 : st1;
                ild  = (i == 0) ? ld3 : ld1;
                merr = (ren && wen) || (addr[31:12] != 20'd0);
                mreq = ren || wen;
                key  = {wen, addr[31:2], wen ? store : 32'd0};
                ix   = addr[11:2];
                es   = 2'd1;
                if (merr) begin
                    es    = 2'd3;
                    kv[i] = 1'b0;
                end else if (!mreq) begin
                    es    = 2'd0;
                    kv[i] = 1'b0;
                end else begin
                    if (!kv[i] || key != kk[i]) begin
                        kv[i]  = 1'b1;
                        kk[i]  = key;
                        age[i] = 0;
                    end
                    if (age[i] == ((i == 0) ? 3 : 1)) begin
                        es    = 2'd2;
                        kv[i] = 1'b0;
                        if (!wen) begin
                            lk[i] = mv[i][ix];
                            if (mv[i][ix]) eld[i] = mm[i][ix];
                        end
                    end
                    age[i]++;
                end
                checks++;
                if (ist !== es) begin
                    errors++;
                    $display("FAIL state[LAT%0d] t=%0t got %0d want %0d", (i == 0) ? 3 : 1, $time, ist, es);
                end
                if (lk[i]) begin
                    checks++;
                    if (ild !== eld[i]) begin
                        errors++;
                        $display("FAIL load[LAT%0d] t=%0t got %h want %h", (i == 0) ? 3 : 1, $time, ild, eld[i]);
                    end
                end
                if (es == 2'd2 && wen) begin
                    mm[i][ix] = store;
                    mv[i][ix] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // hold a request until the chosen instance reports ACCESS (bounded)
    task automatic req(input bit which, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int n, output logic [31:0] v);
        ren = r; wen = w; addr = a; store = d; n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (((which ? st1 : st3) != 2'd2) && n < 40);
        v = which ? ld1 : ld3;
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int k);
        ren = 1'b0; wen = 1'b0;
        repeat (k) @(posedge CLK);
        #1;
    endtask

    int          n;
    logic [31:0] v;

    initial begin
        nRST = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'd0; store = 32'd0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        chk("reset_state", 32'(st3), 32'd0);
        chk("reset_load", ld3, 32'd0);
        idle(3);
        chk("idle_state_lat1", 32'(st1), 32'd0);

        req(0, 0, 1, 32'h40, 32'hDEADBEEF, n, v);
        chk("write40_latency", n, 4);
        req(0, 1, 0, 32'h40, 32'd0, n, v);
        chk("read40_latency", n, 4);
        chk("read40_data", v, 32'hDEADBEEF);
        idle(5);
        @(negedge CLK);
        chk("load_held", ld3, 32'hDEADBEEF);

        @(posedge CLK); #1;
        req(0, 0, 1, 32'h0, 32'h11, n, v);
        req(0, 0, 1, 32'h4, 32'h22, n, v);
        req(0, 1, 0, 32'h0, 32'd0, n, v);
        chk("b2b_first_data", v, 32'h11);
        req(0, 1, 0, 32'h4, 32'd0, n, v);
        chk("b2b_second_latency", n, 4);
        chk("b2b_second_data", v, 32'h22);

        req(0, 0, 1, 32'h80, 32'h5555, n, v);
        req(0, 0, 1, 32'h84, 32'h6666, n, v);
        idle(1);
        ren = 1'b0; wen = 1'b1; addr = 32'h80; store = 32'hAAAA;
        @(posedge CLK); #1;
        req(0, 0, 1, 32'h84, 32'hAAAA, n, v);
        chk("restart_latency", n, 4);
        req(0, 1, 0, 32'h80, 32'd0, n, v);
        chk("restart_old_word", v, 32'h5555);
        req(0, 1, 0, 32'h84, 32'd0, n, v);
        chk("restart_new_word", v, 32'hAAAA);
        idle(1);

        ren = 1'b1; addr = 32'h0;
        repeat (2) @(posedge CLK);
        #1 ren = 1'b0;
        @(negedge CLK);
        chk("abort_read_state", 32'(st3), 32'd0);
        chk("abort_read_load", ld3, 32'hAAAA);
        idle(1);
        wen = 1'b1; addr = 32'h40; store = 32'h12345678;
        repeat (2) @(posedge CLK);
        #1 wen = 1'b0;
        @(negedge CLK);
        chk("abort_write_state", 32'(st3), 32'd0);
        idle(1);
        req(0, 1, 0, 32'h40, 32'd0, n, v);
        chk("abort_write_mem", v, 32'hDEADBEEF);
        idle(1);

        ren = 1'b1; wen = 1'b1; addr = 32'h40;
        @(negedge CLK);
        chk("err_both_lat3", 32'(st3), 32'd3);
        chk("err_both_lat1", 32'(st1), 32'd3);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("err_persist", 32'(st3), 32'd3);
        @(posedge CLK); #1;
        wen = 1'b0; addr = 32'h0001_0000;
        @(negedge CLK);
        chk("err_range", 32'(st3), 32'd3);
        chk("err_load_held", ld3, 32'hDEADBEEF);
        @(posedge CLK); #1;
        req(0, 1, 0, 32'h40, 32'd0, n, v);
        chk("post_err_latency", n, 4);
        chk("post_err_data", v, 32'hDEADBEEF);
        idle(1);

        req(1, 1, 0, 32'h0, 32'd0, n, v);
        chk("lat1_latency", n, 2);
        chk("lat1_data", v, 32'h11);
        idle(1);
        req(1, 0, 1, 32'h100, 32'h77, n, v);
        idle(1);
        nRST = 1'b0; wen = 1'b1; addr = 32'h100; store = 32'h99;
        @(negedge CLK);
        chk("lat1_busy_in_reset", 32'(st1), 32'd1);
        @(posedge CLK); #1;
        nRST = 1'b1; wen = 1'b0;
        idle(1);
        req(1, 1, 0, 32'h100, 32'd0, n, v);
        chk("reset_abort_mem", v, 32'h77);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_latency_ctrl.md
Name: ram_latency_ctrl

Overview:
Word-organised main-memory model with a programmable access latency. It sits directly downstream of the coherency controller, which is its only bus master. It consumes that controller's ramREN/ramWEN/ramaddr/ramstore and returns ramload/ramstate, so cache fills, write-backs and instruction fetches see realistic multi-cycle memory timing. Storage is an internal array of 2^AW 32-bit words.

Parameters:
AW, 10, word-index width; memory holds 2^AW words; byte address bits [AW+1:2] select the word.
LAT, 3, BUSY cycles before ACCESS; legal range 1..15.
LIMIT_CHECK, 1, when 1, addresses with any of bits [31:AW+2] set report ERROR.

Ports:
CLK  input  1  clock, all state changes on rising edge.
nRST  input  1  synchronous active-low reset, sampled on rising CLK.
ramREN  input  1  read request, held by master until ACCESS.
ramWEN  input  1  write request, held by master until ACCESS.
ramaddr  input  32  byte address; bits [1:0] ignored.
ramstore  input  32  write data.
ramload  output  32  read data.
ramstate  output  2  ramstate_t from cpu_types_pkg: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Interface: one clock (CLK). Reset (nRST) is synchronous and active-low.
- Reset (nRST low at a rising edge):
  - State goes to IDLE; counter clears to 0; latched addr/data/op clear.
  - ramload resets to 0. ramstate is FREE after reset with no request present.
  - Memory contents are not cleared.
  - Reset mid-access aborts the access: no write is committed, and the next cycle behaves as IDLE.
- State machine: IDLE, WAIT, DONE.
  - IDLE, no request: ramstate=FREE.
  - IDLE, request present: ramstate=BUSY this cycle. Latch op/addr/data, load cnt=LAT-1. Next state is WAIT if LAT>1, else DONE.
  - WAIT: ramstate=BUSY; cnt decrements each cycle; go to DONE when cnt==0.
  - DONE: ramstate=ACCESS for exactly one cycle.
    - Read: ramload = mem[latched index], combinational from the registered read word, valid in this cycle.
    - Write: mem[latched index] <= latched data at the edge ending DONE.
    - DONE always returns to IDLE.
  - A request still asserted in the next cycle starts a fresh access, with no FREE gap.
- Latency: a request first seen in cycle T gives BUSY in T..T+LAT-1 and ACCESS in T+LAT.
- ramload after DONE: holds the last read value until the next read completes. Writes do not change ramload.
- Restart rule (WAIT or DONE): if ramaddr, ramstore (writes only) or the op differs from the latched value, discard progress and treat the cycle as IDLE with a request. This gives a BUSY output and re-latches; no write is committed.
- Abort: if ramREN and ramWEN are both low in WAIT or DONE, return to IDLE next cycle. Output FREE in that cycle and commit no write.
- Errors: ramREN and ramWEN both high, or an out-of-range address with LIMIT_CHECK=1, gives ramstate=ERROR combinationally in any state.
  - State forces to IDLE; no memory change; ramload held.
  - ERROR persists while the condition persists.
- Priority per cycle: reset > error > abort > restart > normal progression.
- Master handshake: the master treats FREE/ACCESS as "not waiting". FREE is therefore never driven while a legal request is pending.

Test Plan:
- Reset with nRST low 2 cycles, no requests -> ramstate=FREE, ramload=0 on every cycle after reset.
- LAT=3: write 0xDEADBEEF to 0x40 held until ACCESS -> BUSY at T,T+1,T+2, ACCESS at T+3. Then read 0x40 -> ACCESS at T'+3 with ramload=0xDEADBEEF, and ramload still 0xDEADBEEF 5 cycles later.
- Back-to-back reads of 0x0 then 0x4 (mem preloaded 0x11, 0x22) with the address switched in the cycle after ACCESS -> no FREE gap. Second ACCESS arrives exactly LAT cycles after the first ACCESS+1, with ramload=0x22.
- Write to 0x80 with the address changed to 0x84 at the second BUSY cycle -> counter restarts; ACCESS at LAT cycles after the change. mem[0x80] unchanged, mem[0x84] written.
- Read aborted by dropping ramREN in the WAIT state -> FREE next cycle, ramload unchanged. Write aborted the same way -> memory unchanged, verified by a later read.
- ramREN=ramWEN=1 -> ERROR same cycle. Address 0x0001_0000 with AW=10 -> ERROR. Legal read afterwards completes normally in LAT+1 cycles.
- LAT=1 -> BUSY one cycle, ACCESS next. nRST asserted during the BUSY cycle of a write -> target word unchanged.
